// File: rtl/pcie_pkg.sv
// Shared definitions for the PCIe-style receive path: word fields, sizes and
// control FSM state encoding.
package pcie_pkg;

   localparam int unsigned DATA_W      = 6;
   localparam int unsigned DEPTH       = 4;
   localparam int unsigned PTR_W       = 2;

   localparam int unsigned VC_BIT      = 5;
   localparam int unsigned DEST_BIT    = 4;
   localparam int unsigned PAYLOAD_MSB = 3;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_INIT,
      ST_IDLE,
      ST_ACTIVE,
      ST_ERROR
   } state_t;

endpackage

// File: rtl/rx_lane_fifo.sv
// Per-lane circular buffer with occupancy count, registered almost-full pause
// and an overflow strobe for pushes that find the lane full.
module rx_lane_fifo #(
   parameter int unsigned DATA_W = 6,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PTR_W  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              en,
   input  logic              rd,
   input  logic [DATA_W-1:0] data_in,
   input  logic [PTR_W:0]    thresh,
   output logic [DATA_W-1:0] head,
   output logic              empty,
   output logic              pausa,
   output logic              ovf
);

   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count, count_next;
   logic              full, wr;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // A same-cycle read frees a slot, so a full lane still accepts the push.
   assign wr  = push && en && (!full || rd);
   assign ovf = push && full && !rd;

   assign count_next = count + {{PTR_W{1'b0}}, wr} - {{PTR_W{1'b0}}, rd};

   always_ff @(posedge clk) begin
      if (wr) mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         pausa  <= 1'b0;
      end else begin
         if (wr) wr_ptr <= wr_ptr + 1'b1;
         if (rd) rd_ptr <= rd_ptr + 1'b1;
         count <= count_next;
         pausa <= (count_next >= thresh);
      end
   end

endmodule

// File: rtl/pcie_recv.sv
// Receive side: two checked lane FIFOs merged into one popped output stream by
// a round-robin arbiter, supervised by the RESET/INIT/IDLE/ACTIVE/ERROR FSM.
module pcie_recv import pcie_pkg::*; #(
   parameter int unsigned DATA_W = pcie_pkg::DATA_W,
   parameter int unsigned DEPTH  = pcie_pkg::DEPTH,
   parameter int unsigned PTR_W  = pcie_pkg::PTR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [2:0]        umbral_full,
   input  logic              valid_in0,
   input  logic [DATA_W-1:0] data_in0,
   input  logic              valid_in1,
   input  logic [DATA_W-1:0] data_in1,
   input  logic              pop,
   output logic [DATA_W-1:0] data_out,
   output logic              valid_out,
   output logic              pausa0,
   output logic              pausa1,
   output logic [1:0]        error_id,
   output logic              idle_out,
   output logic              active_out,
   output logic              error_out
);

   state_t            state, state_next;
   logic [2:0]        umbral_reg;
   logic [PTR_W:0]    thresh;
   logic              last_grant, grant, sel, pop_ok;
   logic [1:0]        vld, mis, push, rd, empty, ovf, pausa_v;
   logic [DATA_W-1:0] din  [2];
   logic [DATA_W-1:0] head [2];

   assign vld    = {valid_in1, valid_in0};
   assign din[0] = data_in0;
   assign din[1] = data_in1;
   assign pausa0 = pausa_v[0];
   assign pausa1 = pausa_v[1];

   always_comb begin
      if (umbral_reg == '0)
         thresh = (PTR_W+1)'(1);
      else if (32'(umbral_reg) > DEPTH)
         thresh = (PTR_W+1)'(DEPTH);
      else
         thresh = (PTR_W+1)'(umbral_reg);
   end

   for (genvar n = 0; n < 2; n++) begin : g_lane
      assign mis[n]  = vld[n] && (din[n][DEST_BIT] != 1'(n));
      assign push[n] = vld[n] && !mis[n];

      rx_lane_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
         .clk     (clk),
         .rst     (reset),
         .push    (push[n]),
         .en      (state != ST_ERROR),
         .rd      (rd[n]),
         .data_in (din[n]),
         .thresh  (thresh),
         .head    (head[n]),
         .empty   (empty[n]),
         .pausa   (pausa_v[n]),
         .ovf     (ovf[n])
      );
   end

   // Lone non-empty lane wins; with both occupied, the lane not served last.
   assign pop_ok = (state == ST_INIT) || (state == ST_IDLE) || (state == ST_ACTIVE);
   assign grant  = pop && pop_ok && (empty != 2'b11);
   assign sel    = (empty == 2'b00) ? ~last_grant : empty[0];
   assign rd     = grant ? (sel ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         valid_out  <= 1'b0;
         last_grant <= 1'b1;
         error_id   <= '0;
         umbral_reg <= 3'd3;
      end else begin
         valid_out <= grant;
         if (grant) begin
            data_out   <= head[sel];
            last_grant <= sel;
         end
         error_id <= error_id | ovf | mis;
         if (state == ST_INIT) umbral_reg <= umbral_full;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_RESET;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (|error_id) begin
         state_next = ST_ERROR;
      end else begin
         unique case (state)
            ST_RESET:  state_next = ST_INIT;
            ST_INIT:   state_next = init ? ST_INIT : ST_IDLE;
            ST_IDLE:   state_next = init ? ST_INIT :
                                    (empty != 2'b11) ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_next = init ? ST_INIT :
                                    ((empty == 2'b11) && !valid_out) ? ST_IDLE : ST_ACTIVE;
            ST_ERROR:  state_next = ST_ERROR;
            default:   state_next = ST_RESET;
         endcase
      end
   end

   always_comb begin
      idle_out   = (state == ST_IDLE);
      active_out = (state == ST_ACTIVE);
      error_out  = (state == ST_ERROR);
   end

endmodule

// File: tb/tb_pcie_recv.sv
// Scoreboard bench for pcie_recv: a lane/queue model predicts grants, output
// words, pause and error flags each cycle.
module tb_pcie_recv;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       init = 1'b0;
   logic [2:0] umbral_full = 3'd0;
   logic       valid_in0 = 1'b0, valid_in1 = 1'b0, pop = 1'b0;
   logic [5:0] data_in0 = '0, data_in1 = '0;
   logic [5:0] data_out;
   logic       valid_out, pausa0, pausa1, idle_out, active_out, error_out;
   logic [1:0] error_id;

   int errors = 0;
   int checks = 0;

   logic [5:0] q0[$];
   logic [5:0] q1[$];
   logic [5:0] sb[$];
   logic       m_last;
   logic       m_err;
   logic [1:0] m_errid;
   logic [2:0] m_umbral;

   pcie_recv #(.DATA_W(6), .DEPTH(4), .PTR_W(2)) dut (
      .clk(clk), .reset(reset), .init(init), .umbral_full(umbral_full),
      .valid_in0(valid_in0), .data_in0(data_in0),
      .valid_in1(valid_in1), .data_in1(data_in1),
      .pop(pop), .data_out(data_out), .valid_out(valid_out),
      .pausa0(pausa0), .pausa1(pausa1), .error_id(error_id),
      .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
   );

   always #5 clk = ~clk;

   function automatic int thr();
      if (m_umbral == 3'd0) return 1;
      if (m_umbral > 3'd4) return 4;
      return int'(m_umbral);
   endfunction

   // One clock: drive inputs, advance the model, then check all outputs.
   task automatic cycle(input logic v0, input logic [5:0] d0,
                        input logic v1, input logic [5:0] d1, input logic p);
      logic       exp_v, sel, e0, e1;
      logic [5:0] w;
      logic [1:0] new_err;
      valid_in0 = v0; data_in0 = d0; valid_in1 = v1; data_in1 = d1; pop = p;
      exp_v = 1'b0; new_err = 2'b00;
      if (p && !m_err && (q0.size() > 0 || q1.size() > 0)) begin
         if (q0.size() > 0 && q1.size() > 0) sel = ~m_last;
         else sel = (q1.size() > 0);
         w = sel ? q1.pop_front() : q0.pop_front();
         sb.push_back(w);
         m_last = sel;
         exp_v = 1'b1;
      end
      if (v0) begin
         if (d0[4] != 1'b0) new_err[0] = 1'b1;
         else if (q0.size() >= 4) new_err[0] = 1'b1;
         else if (!m_err) q0.push_back(d0);
      end
      if (v1) begin
         if (d1[4] != 1'b1) new_err[1] = 1'b1;
         else if (q1.size() >= 4) new_err[1] = 1'b1;
         else if (!m_err) q1.push_back(d1);
      end
      @(posedge clk); #1;
      m_err   = m_err | (|m_errid);
      m_errid = m_errid | new_err;
      checks++;
      if (valid_out !== exp_v) begin
         errors++;
         $display("FAIL valid_out: got %b expected %b", valid_out, exp_v);
      end
      if (exp_v) begin
         w = sb.pop_front();
         checks++;
         if (data_out !== w) begin
            errors++;
            $display("FAIL data_out: got %h expected %h", data_out, w);
         end
      end
      e0 = (q0.size() >= thr());
      e1 = (q1.size() >= thr());
      checks++;
      if (pausa0 !== e0 || pausa1 !== e1) begin
         errors++;
         $display("FAIL pausa: got %b%b expected %b%b", pausa1, pausa0, e1, e0);
      end
      checks++;
      if (error_id !== m_errid) begin
         errors++;
         $display("FAIL error_id: got %b expected %b", error_id, m_errid);
      end
      valid_in0 = 1'b0; valid_in1 = 1'b0; pop = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
   endtask

   task automatic do_reset(input logic [2:0] u);
      @(posedge clk); #1;
      reset = 1'b1; init = 1'b1; umbral_full = u;
      valid_in0 = 1'b0; valid_in1 = 1'b0; pop = 1'b0;
      #2;
      checks++;
      if (valid_out !== 1'b0 || data_out !== 6'h00 || pausa0 !== 1'b0 ||
          pausa1 !== 1'b0 || error_id !== 2'b00) begin
         errors++;
         $display("FAIL async_reset: got v=%b d=%h p=%b%b e=%b expected all zero",
                  valid_out, data_out, pausa1, pausa0, error_id);
      end
      q0.delete(); q1.delete(); sb.delete();
      m_last = 1'b1; m_err = 1'b0; m_errid = 2'b00; m_umbral = 3'd3;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({idle_out, active_out, error_out} !== 3'b000) begin
         errors++;
         $display("FAIL reset_state: got %b expected 000", {idle_out, active_out, error_out});
      end
      idle_cycles(2);
      init = 1'b0;
      idle_cycles(1);
      m_umbral = u;
      checks++;
      if (idle_out !== 1'b1 || active_out !== 1'b0) begin
         errors++;
         $display("FAIL enter_idle: got idle=%b active=%b expected 1 0", idle_out, active_out);
      end
   endtask

   task automatic test_reset();
      do_reset(3'd2);
   endtask

   task automatic test_round_robin();
      cycle(1'b1, 6'h0A, 1'b1, 6'h15, 1'b0);
      cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      checks++;
      if (active_out !== 1'b1) begin
         errors++;
         $display("FAIL active: got %b expected 1", active_out);
      end
      cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      checks++;
      if (data_out !== 6'h15) begin
         errors++;
         $display("FAIL empty_pop_hold: got %h expected 15", data_out);
      end
      idle_cycles(1);
      checks++;
      if (idle_out !== 1'b1) begin
         errors++;
         $display("FAIL back_to_idle: got %b expected 1", idle_out);
      end
      cycle(1'b1, 6'h01, 1'b1, 6'h12, 1'b0);
      cycle(1'b1, 6'h02, 1'b1, 6'h13, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      idle_cycles(2);
   endtask

   task automatic test_pause();
      cycle(1'b1, 6'h03, 1'b0, 6'h00, 1'b0);
      cycle(1'b1, 6'h05, 1'b0, 6'h00, 1'b0);
      checks++;
      if (pausa0 !== 1'b1 || pausa1 !== 1'b0) begin
         errors++;
         $display("FAIL pause_assert: got %b%b expected 01", pausa1, pausa0);
      end
      for (int i = 0; i < 2; i++) cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      idle_cycles(2);
   endtask

   task automatic test_full_push_pop();
      for (int i = 1; i <= 4; i++) cycle(1'b0, 6'h00, 1'b1, 6'h10 + 6'(i), 1'b0);
      cycle(1'b0, 6'h00, 1'b1, 6'h1F, 1'b1);
      checks++;
      if (error_out !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop_err: got %b expected 0", error_out);
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      idle_cycles(2);
   endtask

   task automatic test_overflow();
      do_reset(3'd7);
      for (int i = 1; i <= 4; i++) cycle(1'b0, 6'h00, 1'b1, 6'h18 + 6'(i), 1'b0);
      cycle(1'b0, 6'h00, 1'b1, 6'h1E, 1'b0);
      idle_cycles(1);
      checks++;
      if (error_out !== 1'b1) begin
         errors++;
         $display("FAIL overflow_error_state: got %b expected 1", error_out);
      end
      cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      cycle(1'b1, 6'h01, 1'b0, 6'h00, 1'b0);
      init = 1'b1;
      idle_cycles(2);
      init = 1'b0;
      checks++;
      if (error_out !== 1'b1 || idle_out !== 1'b0) begin
         errors++;
         $display("FAIL error_sticky: got err=%b idle=%b expected 1 0", error_out, idle_out);
      end
   endtask

   task automatic test_mismatch();
      do_reset(3'd0);
      cycle(1'b1, 6'h07, 1'b0, 6'h00, 1'b0);
      cycle(1'b0, 6'h00, 1'b0, 6'h00, 1'b1);
      init = 1'b1;
      cycle(1'b1, 6'h10, 1'b0, 6'h00, 1'b0);
      idle_cycles(1);
      checks++;
      if (error_out !== 1'b1) begin
         errors++;
         $display("FAIL mismatch_error_state: got %b expected 1", error_out);
      end
      init = 1'b0;
      idle_cycles(1);
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_pause();
      test_full_push_pop();
      test_overflow();
      test_mismatch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
